// File: rtl/geofence_pkg.sv
// Shared types and sizes for the geofence driver and engine.
// Coordinates are CW bits; one frame is NPTS points (target + fence).
package geofence_pkg;

    localparam int CW   = 10;
    localparam int NPTS = 7;
    localparam int IW   = $clog2(NPTS);

    typedef logic [1:0] state_t;

    localparam state_t S_LOAD   = 2'd0;
    localparam state_t S_SEND   = 2'd1;
    localparam state_t S_WAIT   = 2'd2;
    localparam state_t S_REPORT = 2'd3;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } point_t;

endpackage

// File: rtl/geofence_frame_buf.sv
// Seven-entry point store: one registered write port and a
// combinational read port; out-of-range reads return zero.
module geofence_frame_buf
    import geofence_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            we_i,
    input  logic [IW-1:0]   widx_i,
    input  logic [2*CW-1:0] wpt_i,
    input  logic [IW-1:0]   ridx_i,
    output logic [2*CW-1:0] rpt_o
);

    localparam logic [IW-1:0] LASTI = IW'(NPTS - 1);

    point_t mem_q [NPTS];

    // Store accepted points at the write index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NPTS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (widx_i <= LASTI)) begin
            mem_q[widx_i] <= point_t'(wpt_i);
        end
    end

    // Combinational read with a safe default past the last entry
    always_comb begin
        rpt_o = '0;
        if (ridx_i <= LASTI) begin
            rpt_o = mem_q[ridx_i];
        end
    end

endmodule

// File: rtl/geofence_driver.sv
// Host-side transmitter: gathers a frame, streams it to the engine,
// waits for the verdict and hands it back with timeout/error flags.
module geofence_driver
    import geofence_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int FCW     = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [CW-1:0]  in_x,
    input  logic [CW-1:0]  in_y,
    output logic           gf_rst,
    output logic [CW-1:0]  gf_x,
    output logic [CW-1:0]  gf_y,
    input  logic           gf_valid,
    input  logic           gf_is_inside,
    output logic           res_valid,
    input  logic           res_ready,
    output logic           res_inside,
    output logic           res_timeout,
    output logic           res_proto_err,
    output logic [FCW-1:0] frame_cnt
);

    localparam int            TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LASTI = IW'(NPTS - 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            err_q, err_d;
    logic            inside_d, tmo_d;
    logic [FCW-1:0]  cnt_q, cnt_d;
    logic            we;

    logic            gf_rst_q;
    logic [CW-1:0]   gf_x_q, gf_y_q;
    logic            res_valid_q, res_inside_q;
    logic            res_timeout_q, res_proto_err_q;

    logic [2*CW-1:0] rpt;
    point_t          rp;

    assign rp = point_t'(rpt);

    geofence_frame_buf u_buf (
        .clk    (clk),
        .reset  (reset),
        .we_i   (we),
        .widx_i (idx_q),
        .wpt_i  ({in_x, in_y}),
        .ridx_i (idx_d),
        .rpt_o  (rpt)
    );

    // Next-state logic for the frame sequencer, timer and result flags
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        err_d    = err_q;
        inside_d = res_inside_q;
        tmo_d    = res_timeout_q;
        cnt_d    = cnt_q;
        we       = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    we = 1'b1;
                    if (idx_q == LASTI) begin
                        idx_d   = '0;
                        state_d = S_SEND;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (gf_valid) begin
                    err_d = 1'b1;
                end
                if (idx_q == LASTI) begin
                    idx_d   = '0;
                    timer_d = '0;
                    state_d = S_WAIT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (gf_valid) begin
                    inside_d = gf_is_inside;
                    tmo_d    = 1'b0;
                    state_d  = S_REPORT;
                end else if (timer_q == TLAST) begin
                    inside_d = 1'b0;
                    tmo_d    = 1'b1;
                    state_d  = S_REPORT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_REPORT: begin
                if (res_ready) begin
                    cnt_d    = cnt_q + 1'b1;
                    err_d    = 1'b0;
                    inside_d = 1'b0;
                    tmo_d    = 1'b0;
                    state_d  = S_LOAD;
                end else if (gf_valid) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = S_LOAD;
                idx_d   = '0;
            end
        endcase
    end

    // State and registered outputs, all derived from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_LOAD;
            idx_q           <= '0;
            timer_q         <= '0;
            err_q           <= 1'b0;
            cnt_q           <= '0;
            gf_rst_q        <= 1'b1;
            gf_x_q          <= '0;
            gf_y_q          <= '0;
            res_valid_q     <= 1'b0;
            res_inside_q    <= 1'b0;
            res_timeout_q   <= 1'b0;
            res_proto_err_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            timer_q         <= timer_d;
            err_q           <= err_d;
            cnt_q           <= cnt_d;
            gf_rst_q        <= (state_d == S_LOAD);
            gf_x_q          <= (state_d == S_SEND) ? rp.x : '0;
            gf_y_q          <= (state_d == S_SEND) ? rp.y : '0;
            res_valid_q     <= (state_d == S_REPORT);
            res_inside_q    <= inside_d;
            res_timeout_q   <= tmo_d;
            res_proto_err_q <= err_d && (state_d == S_REPORT);
        end
    end

    assign in_ready      = (state_q == S_LOAD);
    assign gf_rst        = gf_rst_q;
    assign gf_x          = gf_x_q;
    assign gf_y          = gf_y_q;
    assign res_valid     = res_valid_q;
    assign res_inside    = res_inside_q;
    assign res_timeout   = res_timeout_q;
    assign res_proto_err = res_proto_err_q;
    assign frame_cnt     = cnt_q;

endmodule

// File: tb/tb_geofence_driver.sv
// Self-checking bench for geofence_driver with a simple engine model
// and a frame-level reference of expected sequence, latency and flags.
module tb_geofence_driver;

    localparam int CW  = 10;
    localparam int NP  = 7;
    localparam int TO  = 64;
    localparam int FCW = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [CW-1:0]  in_x, in_y;
    logic           gf_rst;
    logic [CW-1:0]  gf_x, gf_y;
    logic           gf_valid, gf_is_inside;
    logic           res_valid, res_ready;
    logic           res_inside, res_timeout, res_proto_err;
    logic [FCW-1:0] frame_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_frames = 0;

    logic [CW-1:0] px [NP];
    logic [CW-1:0] py [NP];

    geofence_driver #(.TIMEOUT(TO), .FCW(FCW)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_y         (in_y),
        .gf_rst       (gf_rst),
        .gf_x         (gf_x),
        .gf_y         (gf_y),
        .gf_valid     (gf_valid),
        .gf_is_inside (gf_is_inside),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_inside   (res_inside),
        .res_timeout  (res_timeout),
        .res_proto_err(res_proto_err),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fence(input int tx, input int ty);
        int fx [6] = '{100, 900, 1000, 900, 100, 0};
        int fy [6] = '{100, 100, 500, 900, 900, 500};
        px[0] = CW'(tx);
        py[0] = CW'(ty);
        for (int i = 0; i < 6; i++) begin
            px[i+1] = CW'(fx[i]);
            py[i+1] = CW'(fy[i]);
        end
    endtask

    task automatic set_random_pts();
        for (int i = 0; i < NP; i++) begin
            px[i] = CW'($urandom_range(0, 1023));
            py[i] = CW'($urandom_range(0, 1023));
        end
    endtask

    // Offer the frame with random upstream stalls; ends in SEND cycle 0
    task automatic load_pts(input int stall_pct);
        int  n = 0;
        int  guard = 0;
        bit  v;
        bit  rdy;
        while (n < NP && guard < 500) begin
            v        = ($urandom_range(0, 99) >= stall_pct);
            in_valid = v;
            in_x     = px[n];
            in_y     = py[n];
            rdy      = in_ready;
            step();
            if (v && rdy) n++;
            guard++;
        end
        in_valid = 1'b0;
        checks++;
        if (n != NP) begin
            failures++;
            $display("FAIL load_accepts got=%0d exp=%0d", n, NP);
        end
    endtask

    // Walk the 7 SEND cycles; optionally glitch gf_valid in cycle pk
    task automatic send_check(input int pk);
        for (int k = 0; k < NP; k++) begin
            checks++;
            if (gf_x !== px[k] || gf_y !== py[k] || gf_rst !== 1'b0
                || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL send_k%0d got=(%0d,%0d,rst%b,rdy%b) exp=(%0d,%0d,rst0,rdy0)",
                         k, gf_x, gf_y, gf_rst, in_ready, px[k], py[k]);
            end
            gf_valid     = (k == pk);
            gf_is_inside = 1'b0;
            step();
        end
        gf_valid = 1'b0;
        checks++;
        if (gf_x !== '0 || gf_y !== '0 || gf_rst !== 1'b0) begin
            failures++;
            $display("FAIL wait_entry got=(%0d,%0d,rst%b) exp=(0,0,rst0)",
                     gf_x, gf_y, gf_rst);
        end
    endtask

    // Full frame: load, stream, engine answer after dly WAIT cycles
    // (negative = never), hold REPORT for hold cycles, then handshake
    task automatic run_frame(input int dly, input bit ins, input int pk,
                             input int hold, input int stall);
        int c = 0;
        int exp_c;
        bit answered;
        bit e_in, e_to, e_er;
        logic [FCW-1:0] ef;
        answered = (dly >= 0) && (dly < TO);
        exp_c    = answered ? dly + 1 : TO;
        e_in     = answered ? ins : 1'b0;
        e_to     = !answered;
        e_er     = (pk >= 0);
        load_pts(stall);
        send_check(pk);
        while (!res_valid && c < TO + 8) begin
            gf_valid     = (c == dly);
            gf_is_inside = ins;
            step();
            c++;
        end
        gf_valid     = 1'b0;
        gf_is_inside = 1'b0;
        checks++;
        if (c !== exp_c) begin
            failures++;
            $display("FAIL result_latency got=%0d exp=%0d", c, exp_c);
        end
        for (int h = 0; h <= hold; h++) begin
            checks++;
            if (res_valid !== 1'b1 || res_inside !== e_in || res_timeout !== e_to
                || res_proto_err !== e_er || in_ready !== 1'b0 || gf_rst !== 1'b0) begin
                failures++;
                $display("FAIL report_h%0d got=(v%b i%b t%b e%b rdy%b rst%b) exp=(v1 i%b t%b e%b rdy0 rst0)",
                         h, res_valid, res_inside, res_timeout, res_proto_err,
                         in_ready, gf_rst, e_in, e_to, e_er);
            end
            res_ready = (h == hold);
            step();
        end
        res_ready = 1'b0;
        exp_frames++;
        ef = FCW'(exp_frames);
        checks++;
        if (in_ready !== 1'b1 || gf_rst !== 1'b1 || res_valid !== 1'b0
            || frame_cnt !== ef) begin
            failures++;
            $display("FAIL handshake got=(rdy%b rst%b v%b cnt%0d) exp=(rdy1 rst1 v0 cnt%0d)",
                     in_ready, gf_rst, res_valid, frame_cnt, ef);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || gf_rst !== 1'b1 || gf_x !== '0 || gf_y !== '0
            || res_valid !== 1'b0 || res_inside !== 1'b0 || res_timeout !== 1'b0
            || res_proto_err !== 1'b0 || frame_cnt !== '0) begin
            failures++;
            $display("FAIL reset_state got=(rdy%b rst%b x%0d v%b cnt%0d) exp=(rdy1 rst1 x0 v0 cnt0)",
                     in_ready, gf_rst, gf_x, res_valid, frame_cnt);
        end
    endtask

    task automatic test_inside();
        set_fence(500, 500);
        run_frame(3, 1'b1, -1, 0, 0);
    endtask

    task automatic test_outside();
        set_fence(5, 5);
        run_frame(2, 1'b0, -1, 1, 20);
    endtask

    task automatic test_timeout();
        set_random_pts();
        run_frame(-1, 1'b1, -1, 0, 10);
    endtask

    task automatic test_expiry_edge();
        set_random_pts();
        run_frame(TO - 1, 1'b1, -1, 0, 0);
        set_random_pts();
        run_frame(TO, 1'b1, -1, 0, 0);
    endtask

    task automatic test_hold();
        set_fence(500, 500);
        run_frame(1, 1'b1, -1, 10, 0);
    endtask

    task automatic test_proto();
        set_fence(500, 500);
        run_frame(3, 1'b1, 3, 2, 0);
        set_fence(500, 500);
        run_frame(0, 1'b1, -1, 0, 0);
    endtask

    task automatic test_reset_mid();
        logic [CW-1:0] fx;
        set_random_pts();
        load_pts(0);
        repeat (4) step();
        reset = 1'b1;
        #1;
        checks++;
        if (gf_rst !== 1'b1 || in_ready !== 1'b1 || frame_cnt !== '0
            || gf_x !== '0 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got=(rst%b rdy%b cnt%0d x%0d) exp=(rst1 rdy1 cnt0 x0)",
                     gf_rst, in_ready, frame_cnt, gf_x);
        end
        step();
        reset = 1'b0;
        exp_frames = 0;
        fx = px[0];
        set_random_pts();
        if (px[0] == fx) px[0] = fx ^ 10'h155;
        run_frame(4, 1'b0, -1, 0, 25);
    endtask

    task automatic test_random();
        for (int f = 0; f < 10; f++) begin
            int d;
            int pk;
            set_random_pts();
            d  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 12));
            pk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
            run_frame(d, 1'($urandom_range(0, 1)), pk,
                      int'($urandom_range(0, 4)), 40);
        end
    endtask

    initial begin
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_x         = '0;
        in_y         = '0;
        gf_valid     = 1'b0;
        gf_is_inside = 1'b0;
        res_ready    = 1'b0;
        repeat (3) step();
        test_reset();
        reset = 1'b0;
        step();
        test_inside();
        test_outside();
        test_timeout();
        test_expiry_edge();
        test_hold();
        test_proto();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            set_random_pts();
            run_frame(0, 1'(f), -1, 0, 0);
        end
    endtask

endmodule
